weights_loader: RTL and testbench
=================================

Name: weights_loader

Overview:
- Sequencer that sits directly upstream of the per-kernel weights ROM and drives its read-enable and 5-bit read address.
- Walks addresses 0..KSIZE-1, absorbs the ROM's 1-cycle registered read latency and assembles the returned words into a flattened kernel register bank.
- Presents the complete kernel to the convolution PE with a level-valid flag.
- One instance per ROM; reloads on every accepted start pulse.

Parameters:
- KSIZE, default `CNN_KERNEL_SIZE, number of kernel weights (1..32; bounded by the 5-bit ROM address).
- PW, default `CNN_PARA_WIDTH, weight word width in bits.
- AW, default 5, ROM address width.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  single-cycle load request.
- busy  output  1  high while a load is in progress.
- rom_r_en  output  1  ROM read enable, registered.
- rom_raddr  output  AW  ROM read address, registered.
- rom_dout  input  PW  ROM read data; valid one cycle after rom_r_en is high; the ROM returns 0 when not enabled.
- kernel_flat  output  KSIZE*PW  weights; word i occupies bits [i*PW +: PW].
- kernel_valid  output  1  kernel_flat holds a complete, consistent kernel.

Behaviour:
- Reset, when rst_n is low at a rising edge:
  - State goes to IDLE; busy=0, rom_r_en=0, rom_raddr=0, kernel_valid=0.
  - kernel_flat clears to all-zero; the address counter, capture index and read-valid pipe flag clear.
  - Reset mid-load aborts the load. No partial kernel is ever flagged valid.
- FSM states are IDLE, READ, DRAIN, DONE.
- IDLE / DONE:
  - start=1 is accepted. Next state is READ; busy=1 and kernel_valid=0 from the next cycle.
  - rom_r_en=1 with rom_raddr=0 on the next cycle.
  - The capture index resets to 0.
- READ:
  - rom_r_en=1 and rom_raddr=cnt, with cnt incrementing by 1 per cycle.
  - When cnt==KSIZE-1 is issued, next state is DRAIN. rom_r_en drops to 0 and rom_raddr holds its last value.
- Read-valid pipe flag:
  - rd_vld is a register copy of rom_r_en.
  - When rd_vld=1: kernel word[widx] <= rom_dout, then widx++.
- DRAIN:
  - Waits for the last capture, which occurs in the DRAIN cycle.
  - Next state is DONE, with kernel_valid=1 and busy=0.
- DONE:
  - kernel_valid stays high and kernel_flat is held stable until a new start is accepted.
- start in READ or DRAIN is ignored: no queueing and no restart.
- Latency, with start sampled at edge E0:
  - rom_r_en is high after edges E1..E(KSIZE).
  - kernel_valid rises after edge E(KSIZE+2). This is 27 cycles for KSIZE=25.
- During a reload, kernel_flat words update progressively. Consumers must sample only while kernel_valid=1.
- Widths:
  - cnt is AW bits; widx is ceil(log2(KSIZE+1)) bits.
  - No arithmetic is applied to weights; they are stored bit-exact.

Decomposition:
- cnn_defines.v already supplies CNN_PARA_WIDTH and CNN_KERNEL_SIZE. Add CNN_ROM_ADDR_WIDTH (5) and the FSM state encodings (2-bit) there.
- No sub-module is needed. The capture bank is a simple indexed register array inside the block.
- The bench instantiates the real weights ROM downstream of this block with a known hex file.

Test Plan:
- Reset then idle: rst_n=0 for 3 cycles then 1, no start -> busy=0, rom_r_en=0, rom_raddr=0, kernel_valid=0, kernel_flat=0 held for 20 cycles.
- Basic load, KSIZE=25, ROM file word i = 16'h0100+i:
  - Pulse start at E0 -> rom_r_en high E1..E25 with addresses 0..24.
  - kernel_valid rises after E27; word i of kernel_flat = 16'h0100+i.
- Start while busy: second start pulse at E10 -> ignored; address sequence is unchanged and kernel_valid still rises after E27 exactly once.
- Reload from DONE: start again with a different ROM image (word i = 16'hA000+i) -> kernel_valid drops the cycle after acceptance and re-rises 27 cycles after the start edge with the new data.
- Reset mid-load: rst_n=0 at E12 for 1 cycle -> all outputs return to reset values next cycle and kernel_valid stays 0. A subsequent start produces a full correct load.
- Back-to-back start: start asserted on the same cycle kernel_valid first rises -> accepted; kernel_valid=1 for exactly one cycle, then a fresh 25-address sequence follows.

Source files
------------

// File: rtl/weights_loader_pkg.sv
// Shared constants and FSM encoding for the kernel weights loader.
// Defaults mirror the CNN-wide kernel geometry and the 5-bit weights ROM address.
package weights_loader_pkg;

  localparam int CNN_PARA_WIDTH     = 16;
  localparam int CNN_KERNEL_SIZE    = 25;
  localparam int CNN_ROM_ADDR_WIDTH = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } wl_state_e;

endpackage

// File: rtl/weights_loader.sv
// Walks the weights ROM once per accepted start, absorbs its 1-cycle read latency
// and assembles the returned words into a flattened kernel bank for the PE.
module weights_loader
  import weights_loader_pkg::*;
#(
  parameter int KSIZE = CNN_KERNEL_SIZE,
  parameter int PW    = CNN_PARA_WIDTH,
  parameter int AW    = CNN_ROM_ADDR_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                busy,
  output logic                rom_r_en,
  output logic [AW-1:0]       rom_raddr,
  input  logic [PW-1:0]       rom_dout,
  output logic [KSIZE*PW-1:0] kernel_flat,
  output logic                kernel_valid
);

  localparam int                WIDX_W    = $clog2(KSIZE + 1);
  localparam logic [AW-1:0]     LAST_ADDR = AW'(KSIZE - 1);
  localparam logic [WIDX_W-1:0] LAST_WIDX = WIDX_W'(KSIZE - 1);

  wl_state_e         state_q;
  wl_state_e         state_d;
  logic              accept;
  logic [AW-1:0]     cnt_q;
  logic [WIDX_W-1:0] widx_q;
  logic              rd_vld_q;
  logic [PW-1:0]     kernel_q [KSIZE];

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_READ;
          accept  = 1'b1;
        end
      end
      ST_READ: begin
        if (cnt_q == LAST_ADDR) state_d = ST_DRAIN;
      end
      // The last word is captured at the end of the cycle in which it is in
      // flight, so DONE and the final capture land on the same edge.
      ST_DRAIN: begin
        if (rd_vld_q && (widx_q == LAST_WIDX)) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignment so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rom_r_en     <= 1'b0;
      rom_raddr    <= '0;
      cnt_q        <= '0;
      rd_vld_q     <= 1'b0;
      widx_q       <= '0;
      busy         <= 1'b0;
      kernel_valid <= 1'b0;
    end else begin
      rom_r_en <= (state_q == ST_READ);
      rd_vld_q <= rom_r_en;
      if (state_q == ST_READ) begin
        rom_raddr <= cnt_q;
        cnt_q     <= cnt_q + AW'(1);
      end
      if (accept) begin
        cnt_q  <= '0;
        widx_q <= '0;
      end else if (rd_vld_q) begin
        widx_q <= widx_q + WIDX_W'(1);
      end
      busy         <= (state_d == ST_READ) || (state_d == ST_DRAIN);
      kernel_valid <= (state_d == ST_DONE);
    end
  end

  // NOTE: the bank is a register array, not a RAM, so it can be cleared on
  // reset; this keeps a stale kernel from surviving an aborted load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < KSIZE; i++) kernel_q[i] <= '0;
    end else if (rd_vld_q) begin
      for (int i = 0; i < KSIZE; i++) begin
        if (widx_q == WIDX_W'(i)) kernel_q[i] <= rom_dout;
      end
    end
  end

  for (genvar g = 0; g < KSIZE; g++) begin : g_flat
    assign kernel_flat[g*PW +: PW] = kernel_q[g];
  end

endmodule

// File: tb/tb_weights_loader.sv
// Self-checking bench for weights_loader: ROM model downstream, cycle-level
// reference model of the load timeline, directed scenarios plus random traffic.
module tb_weights_loader;
  import weights_loader_pkg::*;

  localparam int K  = 25;
  localparam int PW = 16;
  localparam int AW = 5;
  localparam int KW = K * PW;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy;
  logic          rom_r_en;
  logic [AW-1:0] rom_raddr;
  logic [PW-1:0] rom_dout;
  logic [KW-1:0] kernel_flat;
  logic          kernel_valid;

  logic [PW-1:0] rom_img [32];

  always #5 clk = ~clk;

  weights_loader #(.KSIZE(K), .PW(PW), .AW(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .busy         (busy),
    .rom_r_en     (rom_r_en),
    .rom_raddr    (rom_raddr),
    .rom_dout     (rom_dout),
    .kernel_flat  (kernel_flat),
    .kernel_valid (kernel_valid)
  );

  // Registered-read weights ROM; returns zero when not enabled
  always @(posedge clk) rom_dout <= rom_r_en ? rom_img[rom_raddr] : '0;

  int compared   = 0;
  int mismatched = 0;
  int rises      = 0;

  task automatic check(input string tag, input logic [KW-1:0] got, input logic [KW-1:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [KW-1:0] img_flat();
    logic [KW-1:0] f;
    for (int i = 0; i < K; i++) f[i*PW +: PW] = rom_img[i];
    return f;
  endfunction

  // Reference model: a load is a timeline relative to its acceptance edge.
  int            edge_n    = 0;
  int            acc       = 0;
  bit            have      = 1'b0;
  bit            chk_en    = 1'b0;
  bit            exp_busy  = 1'b0;
  bit            exp_en    = 1'b0;
  bit            exp_valid = 1'b0;
  logic [AW-1:0] exp_addr  = '0;
  logic [KW-1:0] exp_kernel = '0;
  logic [KW-1:0] img_snap  = '0;

  always @(posedge clk) begin
    int r;
    bit busy_before;
    edge_n++;
    busy_before = have && (edge_n - acc >= 1) && (edge_n - acc <= K + 2);
    if (!rst_n) begin
      have       = 1'b0;
      chk_en     = 1'b1;
      exp_addr   = '0;
      exp_kernel = '0;
    end else if (start && !busy_before) begin
      have     = 1'b1;
      acc      = edge_n;
      img_snap = img_flat();
    end
    r         = edge_n - acc;
    exp_busy  = have && (r <= K + 1);
    exp_en    = have && (r >= 1) && (r <= K);
    exp_valid = have && (r >= K + 2);
    if (exp_en) exp_addr = AW'(r - 1);
    if (have && (r == K + 2)) exp_kernel = img_snap;
  end

  logic prev_valid = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", busy, exp_busy);
      check("rom_r_en", rom_r_en, exp_en);
      check("rom_raddr", rom_raddr, exp_addr);
      check("kernel_valid", kernel_valid, exp_valid);
      if (!have || exp_valid) check("kernel_flat", kernel_flat, exp_kernel);
      if (kernel_valid === 1'b1 && prev_valid !== 1'b1) rises++;
      prev_valid = kernel_valid;
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic set_img_ramp(input logic [PW-1:0] base);
    for (int i = 0; i < 32; i++) rom_img[i] = base + PW'(i);
  endtask

  task automatic set_img_rand();
    for (int i = 0; i < 32; i++) rom_img[i] = PW'($urandom);
  endtask

  initial begin
    int r0;
    set_img_ramp(16'h0100);

    // Reset then idle
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1 check("idle_flat", kernel_flat, '0);

    // Basic load
    r0 = rises;
    pulse_start();
    repeat (K + 3) @(posedge clk);
    #1 check("basic_rises", rises - r0, 1);
    check("basic_kernel", kernel_flat, img_flat());

    // Start while busy is ignored
    r0 = rises;
    pulse_start();
    repeat (9) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (K - 7) @(posedge clk);
    #1 check("busy_start_rises", rises - r0, 1);

    // Reload from DONE with a new image
    set_img_ramp(16'hA000);
    r0 = rises;
    pulse_start();
    repeat (K + 3) @(posedge clk);
    #1 check("reload_rises", rises - r0, 1);
    check("reload_kernel", kernel_flat, img_flat());

    // Reset mid-load, then a full load
    set_img_rand();
    r0 = rises;
    pulse_start();
    repeat (11) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (K + 5) @(posedge clk);
    #1 check("abort_rises", rises - r0, 0);
    check("abort_flat", kernel_flat, '0);
    pulse_start();
    repeat (K + 3) @(posedge clk);
    #1 check("after_abort_kernel", kernel_flat, img_flat());

    // Back-to-back: start on the cycle kernel_valid first rises
    set_img_ramp(16'h5500);
    r0 = rises;
    pulse_start();
    repeat (K + 2) @(posedge clk);
    #1 start = 1'b1;
    set_img_rand();
    @(posedge clk); #1 start = 1'b0;
    repeat (K + 3) @(posedge clk);
    #1 check("b2b_rises", rises - r0, 2);
    check("b2b_kernel", kernel_flat, img_flat());

    // Random traffic
    repeat (3000) begin
      @(posedge clk); #1;
      rst_n = ($urandom_range(199) != 0);
      start = ($urandom_range(7) == 0);
      if (!exp_busy && $urandom_range(9) == 0) set_img_rand();
    end
    #1 start = 1'b0;
    rst_n = 1'b1;
    repeat (K + 5) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
